// File: rtl/eth_pkg.sv
// Shared Ethernet constants and the receive MAC state type.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    // Four FCS bytes plus the one byte held back so tlast can land on it.
    localparam int DLY_BYTES = 5;
    localparam int CNT_W     = 11;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } rx_mac_state_t;

endpackage

// File: rtl/crc32_d8.sv
// Combinational reflected CRC-32 update over one byte, LSB first.
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] c;

    always_comb begin
        c = crc_i ^ {24'h0, data_i};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        crc_o = c;
    end

endmodule

// File: rtl/rgmii_rx_mac.sv
// Receive MAC framer: strips preamble/SFD, checks FCS and length, emits
// AXI-Stream frames with the FCS removed plus per-frame statistics pulses.
module rgmii_rx_mac
    import eth_pkg::*;
#(
    parameter int MIN_FRAME  = 64,
    parameter int MAX_FRAME  = 1518,
    parameter int GAP_CYCLES = 3
) (
    input  logic       rx_mac_aclk,
    input  logic       rx_reset,
    input  logic       link_status,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    output logic       stat_good_frame,
    output logic       stat_bad_fcs,
    output logic       stat_bad_length,
    output logic       stat_preamble_err
);

    localparam int GW = $clog2(GAP_CYCLES + 1);

    rx_mac_state_t                      state_q;
    logic [31:0]                        crc_q, crc_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic [GW-1:0]                      gap_q, gap_d;
    logic [DLY_BYTES-1:0][7:0]          dly_q;
    logic [7:0]                         tdata_q;
    logic                               tvalid_q, tlast_q, tuser_q;
    logic                               good_q, fcs_q, len_q, pre_q;
    logic                               gap_end, crc_bad, too_short;

    crc32_d8 u_crc (
        .crc_i  (crc_q),
        .data_i (s_axis_tdata),
        .crc_o  (crc_d)
    );

    assign cnt_d     = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign gap_d     = s_axis_tvalid ? '0 :
                       (gap_q == GW'(GAP_CYCLES)) ? gap_q : gap_q + GW'(1);
    // True on the cycle that completes the run of idle cycles.
    assign gap_end   = !s_axis_tvalid && (gap_q == GW'(GAP_CYCLES - 1));
    assign crc_bad   = (crc_q != CRC32_RESIDUE);
    assign too_short = (cnt_q < CNT_W'(MIN_FRAME));

    always_ff @(posedge rx_mac_aclk) begin
        if (rx_reset) begin
            state_q  <= IDLE;
            crc_q    <= CRC32_INIT;
            cnt_q    <= '0;
            gap_q    <= '0;
            dly_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
            good_q   <= 1'b0;
            fcs_q    <= 1'b0;
            len_q    <= 1'b0;
            pre_q    <= 1'b0;
        end else begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
            good_q   <= 1'b0;
            fcs_q    <= 1'b0;
            len_q    <= 1'b0;
            pre_q    <= 1'b0;
            gap_q    <= gap_d;

            case (state_q)
                IDLE: begin
                    if (s_axis_tvalid && link_status) begin
                        if (s_axis_tdata == ETH_PREAMBLE) begin
                            state_q <= PREAMBLE;
                        end else if (s_axis_tdata == ETH_SFD) begin
                            state_q <= DATA;
                            cnt_q   <= '0;
                            crc_q   <= CRC32_INIT;
                        end else begin
                            state_q <= DROP;
                            pre_q   <= 1'b1;
                        end
                    end
                end

                PREAMBLE: begin
                    if (!link_status || gap_end) begin
                        state_q <= IDLE;
                    end else if (s_axis_tvalid) begin
                        if (s_axis_tdata == ETH_SFD) begin
                            state_q <= DATA;
                            cnt_q   <= '0;
                            crc_q   <= CRC32_INIT;
                        end else if (s_axis_tdata != ETH_PREAMBLE) begin
                            state_q <= DROP;
                            pre_q   <= 1'b1;
                        end
                    end
                end

                DATA: begin
                    if (!link_status || gap_end) begin
                        // End of frame: the oldest delay-line byte is the last payload byte.
                        if (cnt_q >= CNT_W'(DLY_BYTES)) begin
                            tvalid_q <= 1'b1;
                            tlast_q  <= 1'b1;
                            tuser_q  <= crc_bad | too_short;
                            tdata_q  <= dly_q[DLY_BYTES-1];
                        end
                        good_q  <= !(crc_bad | too_short);
                        fcs_q   <= crc_bad;
                        len_q   <= too_short;
                        state_q <= IDLE;
                    end else if (s_axis_tvalid) begin
                        if (cnt_q == CNT_W'(MAX_FRAME)) begin
                            tvalid_q <= 1'b1;
                            tlast_q  <= 1'b1;
                            tuser_q  <= 1'b1;
                            tdata_q  <= dly_q[DLY_BYTES-1];
                            len_q    <= 1'b1;
                            state_q  <= DROP;
                        end else begin
                            crc_q <= crc_d;
                            cnt_q <= cnt_d;
                            dly_q <= {dly_q[DLY_BYTES-2:0], s_axis_tdata};
                            if (cnt_q >= CNT_W'(DLY_BYTES)) begin
                                tvalid_q <= 1'b1;
                                tdata_q  <= dly_q[DLY_BYTES-1];
                            end
                        end
                    end
                end

                DROP: begin
                    if (gap_end) begin
                        state_q <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_axis_tdata      = tdata_q;
    assign m_axis_tvalid     = tvalid_q;
    assign m_axis_tlast      = tlast_q;
    assign m_axis_tuser      = tuser_q;
    assign stat_good_frame   = good_q;
    assign stat_bad_fcs      = fcs_q;
    assign stat_bad_length   = len_q;
    assign stat_preamble_err = pre_q;

endmodule

// File: tb/tb_rgmii_rx_mac.sv
// Scoreboard bench for rgmii_rx_mac: stimulus pushes expected beats/stats,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_rgmii_rx_mac;

    localparam int GAP = 3;

    logic       clk = 1'b0;
    logic       rx_reset = 1'b1;
    logic       link_status = 1'b1;
    logic [7:0] s_axis_tdata = 8'h00;
    logic       s_axis_tvalid = 1'b0;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid, m_axis_tlast, m_axis_tuser;
    logic       stat_good_frame, stat_bad_fcs, stat_bad_length, stat_preamble_err;

    rgmii_rx_mac #(.MIN_FRAME(64), .MAX_FRAME(1518), .GAP_CYCLES(GAP)) dut (
        .rx_mac_aclk       (clk),
        .rx_reset          (rx_reset),
        .link_status       (link_status),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tvalid     (s_axis_tvalid),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tlast      (m_axis_tlast),
        .m_axis_tuser      (m_axis_tuser),
        .stat_good_frame   (stat_good_frame),
        .stat_bad_fcs      (stat_bad_fcs),
        .stat_bad_length   (stat_bad_length),
        .stat_preamble_err (stat_preamble_err)
    );

    always #4 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       u;
    } beat_t;

    beat_t      exp_q[$];
    logic [3:0] stat_q[$];
    logic [7:0] frm[$];
    int         checks = 0;
    int         failures = 0;
    int         beat_no = 0;

    // Monitor: stats vector is {good, bad_fcs, bad_length, preamble_err}.
    always @(negedge clk) begin
        beat_t      e;
        logic [3:0] s, se;
        if (m_axis_tvalid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL beat_unexpected #%0d got d=%02h l=%0b u=%0b req none",
                         beat_no, m_axis_tdata, m_axis_tlast, m_axis_tuser);
            end else begin
                e = exp_q.pop_front();
                if ({m_axis_tdata, m_axis_tlast, m_axis_tuser} !== e) begin
                    failures++;
                    $display("FAIL beat #%0d got d=%02h l=%0b u=%0b req d=%02h l=%0b u=%0b",
                             beat_no, m_axis_tdata, m_axis_tlast, m_axis_tuser, e.d, e.l, e.u);
                end
            end
            beat_no++;
        end
        s = {stat_good_frame, stat_bad_fcs, stat_bad_length, stat_preamble_err};
        if (s != 4'b0000) begin
            checks++;
            if (stat_q.size() == 0) begin
                failures++;
                $display("FAIL stat_unexpected got %04b req none", s);
            end else begin
                se = stat_q.pop_front();
                if (s !== se) begin
                    failures++;
                    $display("FAIL stat got %04b req %04b", s, se);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [7:0] d);
        @(posedge clk);
        #1;
        s_axis_tvalid = v;
        s_axis_tdata  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00);
    endtask

    task automatic put(input logic [7:0] d, input bit slow);
        drive(1'b1, d);
        if (slow) drive(1'b0, 8'h00);
    endtask

    function automatic logic [31:0] crc_of(input logic [7:0] b[$]);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            c = c ^ {24'h0, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    // Frame of n bytes incl. FCS; flip >= 0 corrupts that byte after the FCS is appended.
    task automatic build(input int n, input int flip);
        logic [31:0] c;
        frm.delete();
        for (int i = 0; i < n - 4; i++) frm.push_back(8'((i * 13 + 5) & 255));
        c = ~crc_of(frm);
        for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
        if (flip >= 0) frm[flip] = frm[flip] ^ 8'hFF;
    endtask

    task automatic send(input int npre, input bit slow);
        for (int i = 0; i < npre; i++) put(8'h55, slow);
        put(8'hD5, slow);
        foreach (frm[i]) put(frm[i], slow);
    endtask

    task automatic expect_normal();
        int   n = frm.size();
        logic bad_fcs, short_f;
        bad_fcs = (crc_of(frm) != 32'hDEBB20E3);
        short_f = (n < 64);
        if (n >= 5) begin
            for (int i = 0; i <= n - 5; i++)
                exp_q.push_back(beat_t'({frm[i], (i == n - 5), (i == n - 5) && (bad_fcs || short_f)}));
        end
        stat_q.push_back({!(bad_fcs || short_f), bad_fcs, short_f, 1'b0});
    endtask

    task automatic check_quiet(input string name);
        logic [11:0] o;
        o = {m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
             stat_good_frame | stat_bad_fcs | stat_bad_length | stat_preamble_err};
        checks++;
        if (o !== 12'h000) begin
            failures++;
            $display("FAIL %s outputs got %03h req 000", name, o);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset_state");
        rx_reset = 1'b0;
        idle(4);

        // Good 64-byte frame, gigabit cadence.
        build(64, -1); expect_normal(); send(7, 1'b0); idle(8);
        // Corrupted payload byte 20.
        build(64, 20); expect_normal(); send(7, 1'b0); idle(8);
        // Good frame at 10/100 cadence.
        build(64, -1); expect_normal(); send(7, 1'b1); idle(8);
        // Runt with valid FCS.
        build(40, -1); expect_normal(); send(7, 1'b0); idle(8);

        // Oversize: 1514 beats, last carries tlast+tuser, then a good frame.
        build(1600, -1);
        for (int i = 0; i <= 1513; i++)
            exp_q.push_back(beat_t'({frm[i], (i == 1513), (i == 1513)}));
        stat_q.push_back(4'b0010);
        send(7, 1'b0); idle(8);
        build(64, -1); expect_normal(); send(7, 1'b0); idle(8);

        // Tiny frame (3 bytes): no beats, length error.
        frm.delete(); frm.push_back(8'h01); frm.push_back(8'h02); frm.push_back(8'h03);
        expect_normal(); send(7, 1'b0); idle(8);

        // Bad preamble followed by trailing junk.
        stat_q.push_back(4'b0001);
        put(8'h55, 1'b0); put(8'h55, 1'b0); put(8'h00, 1'b0);
        for (int i = 0; i < 20; i++) put(8'h11, 1'b0);
        idle(8);

        // SFD-only preamble, frame ended by link drop.
        build(64, -1); expect_normal(); send(0, 1'b0);
        @(posedge clk); #1; s_axis_tvalid = 1'b0; link_status = 1'b0;
        @(posedge clk); #1; link_status = 1'b1;
        idle(8);

        // Reset at data byte 30: beats 0..24 only, then silence, then a good frame.
        build(64, -1);
        for (int i = 0; i <= 24; i++) exp_q.push_back(beat_t'({frm[i], 1'b0, 1'b0}));
        for (int i = 0; i < 7; i++) put(8'h55, 1'b0);
        put(8'hD5, 1'b0);
        for (int i = 0; i < 30; i++) put(frm[i], 1'b0);
        @(posedge clk); #1; rx_reset = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = frm[30];
        @(posedge clk); #1;
        check_quiet("reset_midframe");
        rx_reset = 1'b0; s_axis_tvalid = 1'b0;
        idle(4);
        build(64, -1); expect_normal(); send(7, 1'b0); idle(8);

        for (int i = 0; i < 50 && (exp_q.size() != 0 || stat_q.size() != 0); i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL beats_missing got %0d left req 0", exp_q.size());
        end
        checks++;
        if (stat_q.size() != 0) begin
            failures++;
            $display("FAIL stats_missing got %0d left req 0", stat_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
